flopr_pipe: RTL and testbench
=============================

// Module: flopr_pipe
// PURPOSE
//  Parametrised elastic register pipeline; successor to the single 4-bit resettable flop.
//  Chains DEPTH stages of WIDTH-bit data, each with a valid bit and valid/ready flow control.
//  Bubbles collapse: a stage accepts new data whenever it is empty or its contents move on.
//  Used as a timing-closure and delay-line element between datapath blocks.
// PARAMETERS
//  WIDTH      4          data width in bits, >=1
//  DEPTH      3          number of register stages, >=1 (DEPTH=0 is a compile-time error)
//  RESET_VAL  '0         WIDTH-bit value loaded into every data stage on reset
// PORTS
//  clk        in   1                     rising-edge clock
//  reset_n    in   1                     asynchronous, active-low reset
//  flush      in   1                     synchronous clear of all valid bits
//  in_valid   in   1                     upstream data valid
//  in_ready   out  1                     pipeline can accept in_data this cycle
//  in_data    in   WIDTH                 upstream data
//  out_valid  out  1                     last stage holds valid data
//  out_ready  in   1                     downstream accepts out_data this cycle
//  out_data   out  WIDTH                 last-stage data
//  occupancy  out  $clog2(DEPTH+1)       number of valid stages, 0..DEPTH
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous, independent of clk):
//    all valid bits 0, all data stages = RESET_VAL, out_valid=0, out_data=RESET_VAL, occupancy=0.
//    The pipeline leaves reset on the first rising edge after reset_n goes high.
//  - Stage index 0 is the input side, DEPTH-1 drives out_*. v[i] is the valid bit, d[i] the data.
//  - Ready chain (combinational):
//    rdy[DEPTH-1] = out_ready | ~v[DEPTH-1]
//    rdy[i] = rdy[i+1] | ~v[i]
//    in_ready = rdy[0] & ~flush
//  - Per edge, for stage i:
//    if rdy[i], stage i loads from its source (stage i-1, or in_* for i=0):
//      v[i] <= src_valid, d[i] <= src_data.
//    The source data loads whether or not src_valid is set.
//    Otherwise stage i holds.
//  - Transfer: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
//  - Latency: DEPTH cycles from input transfer to out_valid when out_ready is held at 1.
//    Throughput is 1 item per cycle.
//  - Stall: with out_ready=0 the stages fill from the output end.
//    in_ready falls only when all DEPTH stages are valid.
//    No item is ever dropped or duplicated.
//  - Flush (sync): at the edge, all v[i] <= 0 and data regs hold their value.
//    in_ready=0 during flush, so the input is never accepted.
//    out_valid stays at its current value until that edge.
//    A transfer that completes on the flush cycle counts as delivered.
//  - Full case: occupancy=DEPTH with out_ready=1 gives in_ready=1.
//    Simultaneous in/out transfer keeps occupancy at DEPTH.
//  - Empty case: occupancy=0 gives out_valid=0.
//    out_data then shows stale/RESET_VAL data and is don't-care for checkers.
//  - occupancy = popcount(v), combinational from the registers, never exceeds DEPTH.
//  - Reset mid-stream: all in-flight items are discarded immediately (asynchronously).
// STRUCTURE
//  - Shared package flopr_pkg: default WIDTH/DEPTH localparams and a popcount function.
//  - Sub-module flopenr_stage (WIDTH, RESET_VAL): one data+valid register.
//    Ports: async active-low reset, load enable, sync valid clear.
//  - Top: a generate loop of DEPTH flopenr_stage instances, plus the ready chain and occupancy logic.
// TESTING (WIDTH=4, DEPTH=3, RESET_VAL=4'h0)
//  - Reset: drive reset_n=0 at t=2ns mid-cycle.
//    Required: out_valid=0, out_data=0, occupancy=0 before the next edge.
//  - Streaming: out_ready=1, send A,C,F on 3 consecutive cycles.
//    Required: out_data = A,C,F on cycles 3,4,5 with out_valid=1.
//  - Backpressure: out_ready=0, send 1,2,3,4.
//    Required: 1,2,3 accepted, occupancy=3, in_ready=0, 4 held.
//    Then out_ready=1: out 1,2,3,4 in order, no gaps after the first.
//  - Bubble collapse: send 5, idle one cycle, send 6, with out_ready=0.
//    Required: occupancy=2, and 5 and 6 sit in stages 2 and 1 with no bubble.
//  - Flush: occupancy=2, assert flush one cycle with in_valid=1 and data 9.
//    Required: in_ready=0, occupancy=0 next cycle, 9 never appears at the output.
//  - Async reset mid-stream: pipe full of B,C,D, pulse reset_n low for 1ns between edges.
//    Required: occupancy=0 immediately, and only new data appears after release.

Source files
------------

// File: rtl/flopr_pkg.sv
// Shared definitions for the flopr_pipe elastic register pipeline.
//  - DEFAULT_WIDTH / DEFAULT_DEPTH : default geometry used by the pipeline and its stages
//  - POPCOUNT_MAX                  : widest valid vector popcount() can count
//  - popcount()                    : number of set bits, used for the occupancy output
package flopr_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_DEPTH = 3;
    localparam int unsigned POPCOUNT_MAX  = 64;

    function automatic int unsigned popcount(input logic [POPCOUNT_MAX-1:0] bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(POPCOUNT_MAX); i++) begin
            n += 32'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/flopenr_stage.sv
// One stage of the elastic pipeline: a WIDTH-bit data register plus its valid bit.
// Ports:
//  clk      in   rising-edge clock
//  reset_n  in   asynchronous active-low reset (valid=0, data=RESET_VAL)
//  load_i   in   load valid_i/data_i into the stage this edge
//  clr_i    in   synchronous valid clear; data holds, overrides load_i
//  valid_i  in   incoming valid bit
//  data_i   in   incoming data
//  valid_o  out  registered valid bit
//  data_o   out  registered data
module flopenr_stage
    import flopr_pkg::*;
#(
    parameter int unsigned           WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // A clear drops only the valid bit; the data register keeps its old contents
    // even if a load was also requested in the same cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/flopr_pipe.sv
// Parametrised elastic register pipeline with valid/ready flow control.
// DEPTH stages of WIDTH-bit data; bubbles collapse because a stage loads
// whenever it is empty or its contents are moving on.
// Ports:
//  clk        in   rising-edge clock
//  reset_n    in   asynchronous active-low reset, discards all items
//  flush      in   synchronous clear of all valid bits (input not accepted)
//  in_valid   in   upstream data valid
//  in_ready   out  pipeline accepts in_data this cycle
//  in_data    in   upstream data
//  out_valid  out  last stage holds valid data
//  out_ready  in   downstream accepts out_data this cycle
//  out_data   out  last-stage data
//  occupancy  out  number of valid stages, 0..DEPTH
module flopr_pipe
    import flopr_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned      DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1) begin : g_bad_depth
        $error("flopr_pipe: DEPTH must be at least 1");
    end
    if (DEPTH > POPCOUNT_MAX) begin : g_too_deep
        $error("flopr_pipe: DEPTH exceeds popcount width");
    end

    logic [DEPTH-1:0] v_q;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [DEPTH-1:0] rdy;

    // A stage can take new data if it is empty or everything ahead of it can move.
    always_comb begin
        rdy            = '0;
        rdy[DEPTH-1]   = out_ready | ~v_q[DEPTH-1];
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            rdy[i] = rdy[i+1] | ~v_q[i];
        end
    end

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (i == 0) begin : g_src_in
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_src_prev
            assign src_valid = v_q[i-1];
            assign src_data  = d_q[i-1];
        end

        // Stage 0 loads on rdy[0] even during flush; the clear wins so nothing is accepted.
        flopenr_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .load_i  (rdy[i]),
            .clr_i   (flush),
            .valid_i (src_valid),
            .data_i  (src_data),
            .valid_o (v_q[i]),
            .data_o  (d_q[i])
        );
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = OCC_W'(popcount(POPCOUNT_MAX'(v_q)));

endmodule

// File: tb/tb_flopr_pipe.sv
`timescale 1ns/100ps
module tb_flopr_pipe;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: items in arrival order (index 0 = oldest) with the stage
    // position each one has reached. Items advance one stage per cycle unless
    // they would run into the item ahead; the oldest leaves from the last stage.
    int unsigned m_data[$];
    int          m_pos[$];

    flopr_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (4'h0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit exp_in_ready(bit fl, bit ordy);
        return !fl && (ordy || m_data.size() < DEPTH);
    endfunction

    function automatic bit exp_out_valid();
        return m_data.size() > 0 && m_pos[0] == DEPTH - 1;
    endfunction

    function automatic void model_reset();
        m_data.delete();
        m_pos.delete();
    endfunction

    function automatic void model_step(bit iv, int unsigned id, bit ordy, bit fl);
        bit accept;
        accept = iv && exp_in_ready(fl, ordy);
        if (fl) begin
            model_reset();
            return;
        end
        if (exp_out_valid() && ordy) begin
            void'(m_data.pop_front());
            void'(m_pos.pop_front());
        end
        for (int k = 0; k < m_pos.size(); k++) begin
            int lim;
            int np;
            lim = (k == 0) ? DEPTH - 1 : m_pos[k-1] - 1;
            np  = m_pos[k] + 1;
            if (np > lim) np = lim;
            m_pos[k] = np;
        end
        if (accept) begin
            m_data.push_back(id);
            m_pos.push_back(0);
        end
    endfunction

    // Drive inputs just after the falling edge, then compare combinational outputs.
    task automatic apply(input bit iv, input logic [3:0] id, input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        check("in_ready", 32'(in_ready), 32'(exp_in_ready(fl, ordy)));
        check("occupancy", 32'(occupancy), 32'(m_data.size()));
        check("out_valid", 32'(out_valid), 32'(exp_out_valid()));
        if (exp_out_valid()) check("out_data", 32'(out_data), m_data[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(in_valid, 32'(in_data), out_ready, flush);
        @(negedge clk);
    endtask

    initial begin
        // Reset asserted mid-cycle, before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst occupancy", 32'(occupancy), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Streaming A, C, F with out_ready held high.
        apply(1, 4'hA, 1, 0); tick();
        apply(1, 4'hC, 1, 0); tick();
        apply(1, 4'hF, 1, 0); tick();
        apply(0, 4'h0, 1, 0);
        check("stream A", 32'({out_valid, out_data}), 32'h1A);
        tick();
        apply(0, 4'h0, 1, 0);
        check("stream C", 32'({out_valid, out_data}), 32'h1C);
        tick();
        apply(0, 4'h0, 1, 0);
        check("stream F", 32'({out_valid, out_data}), 32'h1F);
        tick();
        apply(0, 4'h0, 1, 0); tick();

        // Backpressure: 1,2,3 fill the pipe, 4 waits.
        apply(1, 4'h1, 0, 0); tick();
        apply(1, 4'h2, 0, 0); tick();
        apply(1, 4'h3, 0, 0); tick();
        apply(1, 4'h4, 0, 0);
        check("bp full occ", 32'(occupancy), 32'd3);
        check("bp in_ready", 32'(in_ready), 32'd0);
        tick();
        apply(1, 4'h4, 1, 0);
        check("bp full+ordy in_ready", 32'(in_ready), 32'd1);
        check("bp out 1", 32'({out_valid, out_data}), 32'h11);
        tick();
        apply(0, 4'h0, 1, 0);
        check("bp out 2", 32'({out_valid, out_data}), 32'h12);
        tick();
        apply(0, 4'h0, 1, 0);
        check("bp out 3", 32'({out_valid, out_data}), 32'h13);
        tick();
        apply(0, 4'h0, 1, 0);
        check("bp out 4", 32'({out_valid, out_data}), 32'h14);
        tick();
        apply(0, 4'h0, 1, 0);
        check("bp drained", 32'(occupancy), 32'd0);
        tick();

        // Bubble collapse: 5, idle, 6 with the output stalled.
        apply(1, 4'h5, 0, 0); tick();
        apply(0, 4'h0, 0, 0); tick();
        apply(1, 4'h6, 0, 0); tick();
        apply(0, 4'h0, 0, 0); tick();
        apply(0, 4'h0, 0, 0);
        check("bubble occ", 32'(occupancy), 32'd2);
        check("bubble head", 32'({out_valid, out_data}), 32'h15);
        tick();

        // Flush with 9 offered on the input.
        apply(1, 4'h9, 0, 1);
        check("flush in_ready", 32'(in_ready), 32'd0);
        tick();
        apply(0, 4'h0, 1, 0);
        check("flush occ", 32'(occupancy), 32'd0);
        check("flush out_valid", 32'(out_valid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(0, 4'h0, 1, 0);
            check("no 9 after flush", 32'(out_valid), 32'd0);
            tick();
        end

        // Async reset with B, C, D in flight.
        apply(1, 4'hB, 0, 0); tick();
        apply(1, 4'hC, 0, 0); tick();
        apply(1, 4'hD, 0, 0); tick();
        apply(0, 4'h0, 0, 0);
        check("pre-rst occ", 32'(occupancy), 32'd3);
        #1 reset_n = 1'b0;
        #0.5;
        check("async rst occ", 32'(occupancy), 32'd0);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        #0.5 reset_n = 1'b1;
        model_reset();
        tick();
        apply(1, 4'h7, 1, 0); tick();
        apply(0, 4'h0, 1, 0); tick();
        apply(0, 4'h0, 1, 0); tick();
        apply(0, 4'h0, 1, 0);
        check("post-rst new data", 32'({out_valid, out_data}), 32'h17);
        tick();
        apply(0, 4'h0, 1, 0);
        check("post-rst empty", 32'(occupancy), 32'd0);
        tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit          iv;
            bit          ordy;
            bit          fl;
            logic [3:0]  rd;
            iv   = ($urandom_range(3, 0) != 0);
            ordy = ($urandom_range(2, 0) != 0);
            fl   = ($urandom_range(23, 0) == 0);
            rd   = 4'($urandom_range(15, 0));
            apply(iv, rd, ordy, fl);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
